// File: rtl/siso.sv
`default_nettype none
// ============================================================================
// Module   : siso
// Brief    : Serial-in serial-out bit-delay line built from a chain of
//            async-clear D flops. Define SISO_TAP_EN to expose every stage on q.
// Revision : 1.0  initial release
// ============================================================================

module siso_dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= 1'b0;
    else      r_q <= d;
  end

  assign q = r_q;

endmodule

module siso #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  output logic             s_out
`ifdef SISO_TAP_EN
  ,
  output logic [DEPTH-1:0] q
`endif
);

  logic [DEPTH-1:0] w_stage;

  // Stage 0 samples the serial input; every later stage samples its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      siso_dff u_dff (
        .clk (clk),
        .rst (rst),
        .d   (s_in),
        .q   (w_stage[i])
      );
    end else begin : g_next
      siso_dff u_dff (
        .clk (clk),
        .rst (rst),
        .d   (w_stage[i-1]),
        .q   (w_stage[i])
      );
    end
  end

  assign s_out = w_stage[DEPTH-1];

`ifdef SISO_TAP_EN
  assign q = w_stage;
`endif

endmodule

`default_nettype wire

// File: tb/tb_siso.sv
`default_nettype none
// ============================================================================
// Module   : tb_siso
// Brief    : Directed-vector bench for siso at DEPTH=4 and DEPTH=1.
// Revision : 1.0  initial release
// ============================================================================

module tb_siso;

  logic       clk;
  logic       rst;
  logic       s_in;
  logic       s_out;
  logic       s_in1;
  logic       s_out1;
`ifdef SISO_TAP_EN
  logic [3:0] q;
  logic [0:0] q1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  siso #(.DEPTH(4)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_in),
    .s_out (s_out)
`ifdef SISO_TAP_EN
    ,
    .q     (q)
`endif
  );

  siso #(.DEPTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_in1),
    .s_out (s_out1)
`ifdef SISO_TAP_EN
    ,
    .q     (q1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive both inputs, advance one rising edge, then settle 2ns past it.
  task automatic step(input logic b, input logic b1);
    s_in  = b;
    s_in1 = b1;
    @(posedge clk);
    #2;
  endtask

  // Pattern vectors for DEPTH=4: s_out after edge k is s_in from edge k-3.
  logic [12:0] pat_in   = 13'b1011001000000;
  logic [12:0] pat_out  = 13'b0001011001000;
  // Post-reset recovery: new bits 1,1,0,1 appear only after the flushed zeros.
  logic [6:0]  rec_in   = 7'b1101000;
  logic [6:0]  rec_out  = 7'b0001101;
  // DEPTH=1 follows its input by exactly one edge.
  logic [5:0]  d1_in    = 6'b100110;

  initial begin
    rst   = 1'b0;
    s_in  = 1'b1;
    s_in1 = 1'b1;
    #1;
    check("reset_t0_s_out", s_out, 1'b0);
    check("reset_t0_s_out1", s_out1, 1'b0);

    // Reset held with s_in=1 and a running clock.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1);
      check("reset_hold_s_out", s_out, 1'b0);
      check("reset_hold_s_out1", s_out1, 1'b0);
`ifdef SISO_TAP_EN
      check("reset_hold_q", q, 4'b0000);
`endif
    end

    rst = 1'b1;

    for (int k = 0; k < 13; k++) begin
      step(pat_in[12-k], 1'b0);
      check($sformatf("pattern_e%0d", k + 1), s_out, pat_out[12-k]);
    end

    // Single pulse walks through the taps and leaves exactly once.
    for (int k = 0; k < 6; k++) begin
      step(k == 0, 1'b0);
      check($sformatf("pulse_e%0d", k + 1), s_out, k == 3);
`ifdef SISO_TAP_EN
      check($sformatf("pulse_q_e%0d", k + 1), q, (k < 4) ? (4'b0001 << k) : 4'b0000);
`endif
    end

    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    check("full_ones_s_out", s_out, 1'b1);
`ifdef SISO_TAP_EN
    check("full_ones_q", q, 4'b1111);
`endif

    // Asynchronous assertion between edges clears everything at once.
    rst = 1'b0;
    #1;
    check("async_rst_s_out", s_out, 1'b0);
`ifdef SISO_TAP_EN
    check("async_rst_q", q, 4'b0000);
`endif
    step(1'b1, 1'b1);
    check("rst_edge_s_out", s_out, 1'b0);
    check("rst_edge_s_out1", s_out1, 1'b0);

    rst = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step(rec_in[6-k], 1'b0);
      check($sformatf("recover_e%0d", k + 1), s_out, rec_out[6-k]);
    end

    for (int k = 0; k < 6; k++) begin
      step(1'b0, d1_in[5-k]);
      check($sformatf("depth1_e%0d", k + 1), s_out1, d1_in[5-k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
